ram_port_arbiter: RTL and testbench

- Shares the single main-RAM port between the instruction-fetch requester and the data-access requester.
- Sits between the instruction-side and data-side bus decoders and the SRAM controller.
- Latches the winning request, holds it stable on the RAM port until the controller completes it, then steers the read data back to the owner.
- Stalls the losing requester and flags a RAM completion that takes too long.

---
 rtl/ram_port_arbiter.sv | 90 +++++++++
 tb/tb_ram_port_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between instruction fetch and data access, latching the winner until the RAM completes it
module ram_port_arbiter #(
  parameter int ADDR_WIDTH     = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_read,
  input  logic [ADDR_WIDTH-1:0] inst_address,
  output logic [31:0]           inst_data_rd,
  output logic [31:0]           inst_data_rd_2,
  output logic                  inst_stall,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [3:0]            data_mask,
  input  logic [31:0]           data_wr,
  output logic [31:0]           data_data_rd,
  output logic                  data_stall,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [3:0]            ram_mask,
  output logic [31:0]           ram_data_wr,
  input  logic [31:0]           ram_data_rd,
  input  logic [31:0]           ram_data_rd_2,
  input  logic                  ram_stall,
  output logic                  err_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;
  state_t state, nxt_state;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [3:0] lat_mask;
  logic [31:0] lat_wr;
  logic lat_read, lat_write;
  logic [CW-1:0] wait_cnt, nxt_cnt;
  logic inst_req, data_req, busy, done, grant_data, grant_inst;
  always_comb begin
    inst_req   = inst_read;
    data_req   = data_read | data_write;
    busy       = state != IDLE;
    done       = busy & ~ram_stall;
    grant_data = data_req & (state == IDLE | (state == INST & ~ram_stall));
    grant_inst = inst_req & ((state == IDLE & ~data_req) | (state == DATA & ~ram_stall));
    nxt_state  = grant_data ? DATA : grant_inst ? INST : done ? IDLE : state;
    nxt_cnt    = (grant_data | grant_inst) ? '0 :
                 (busy & ram_stall & wait_cnt != CW'(TIMEOUT_CYCLES)) ? wait_cnt + 1'b1 : wait_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_addr    <= '0;
      lat_mask    <= '0;
      lat_wr      <= '0;
      lat_read    <= 1'b0;
      lat_write   <= 1'b0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= nxt_state;
      wait_cnt    <= nxt_cnt;
      err_timeout <= err_timeout | (nxt_cnt == CW'(TIMEOUT_CYCLES));
      if (grant_data) begin
        lat_addr  <= data_address;
        lat_mask  <= data_mask;
        lat_wr    <= data_wr;
        lat_read  <= data_read & ~data_write;
        lat_write <= data_write;
      end else if (grant_inst) begin
        lat_addr  <= inst_address;
        lat_mask  <= 4'b1111;
        lat_wr    <= '0;
        lat_read  <= 1'b1;
        lat_write <= 1'b0;
      end
    end
  end
  // RAM port is quiet in IDLE regardless of what the latches still hold
  assign ram_read       = busy & lat_read;
  assign ram_write      = busy & lat_write;
  assign ram_address    = busy ? lat_addr : '0;
  assign ram_mask       = busy ? lat_mask : '0;
  assign ram_data_wr    = busy ? lat_wr : '0;
  assign inst_data_rd   = state == INST ? ram_data_rd : '0;
  assign inst_data_rd_2 = state == INST ? ram_data_rd_2 : '0;
  assign data_data_rd   = state == DATA ? ram_data_rd : '0;
  assign inst_stall     = inst_req & ~(state == INST & ~ram_stall);
  assign data_stall     = data_req & ~(state == DATA & ~ram_stall);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus with a RAM-op scoreboard checked by an independent monitor
module tb_ram_port_arbiter;
  localparam int AW = 20;
  logic clk = 1'b0, rst = 1'b1;
  logic inst_read = 0, data_read = 0, data_write = 0, ram_stall = 0;
  logic [AW-1:0] inst_address = '0, data_address = '0, ram_address;
  logic [3:0] data_mask = '0, ram_mask;
  logic [31:0] data_wr = '0, ram_data_wr, inst_data_rd, inst_data_rd_2, data_data_rd;
  logic [31:0] ram_data_rd = 32'h1111_2222, ram_data_rd_2 = 32'h3333_4444;
  logic inst_stall, data_stall, ram_read, ram_write, err_timeout;
  typedef struct packed {logic rd; logic wr; logic [AW-1:0] addr; logic [3:0] mask; logic [31:0] wdata; logic inst;} op_t;
  op_t exp_q[$];
  int checks = 0, failures = 0;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .inst_read(inst_read), .inst_address(inst_address), .inst_data_rd(inst_data_rd),
    .inst_data_rd_2(inst_data_rd_2), .inst_stall(inst_stall),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_mask(data_mask), .data_wr(data_wr), .data_data_rd(data_data_rd), .data_stall(data_stall),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address), .ram_mask(ram_mask),
    .ram_data_wr(ram_data_wr), .ram_data_rd(ram_data_rd), .ram_data_rd_2(ram_data_rd_2),
    .ram_stall(ram_stall), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [3:0] m, input logic [31:0] d, input logic inst);
    return '{rd: rd, wr: wr, addr: a, mask: m, wdata: d, inst: inst};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every active RAM cycle must match the oldest outstanding op; the op retires on its completion cycle
  always @(negedge clk) begin
    op_t e;
    if (ram_read === 1'b1 || ram_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_op: rd=%0b wr=%0b addr=%0h with nothing expected", ram_read, ram_write, ram_address);
      end else begin
        e = exp_q[0];
        check("ram_port", {ram_read, ram_write, ram_address, ram_mask, ram_data_wr},
              {e.rd, e.wr, e.addr, e.mask, e.wdata});
        if (ram_stall === 1'b0) begin
          if (e.inst)
            check("inst_return", {inst_data_rd, inst_data_rd_2, data_data_rd}, {ram_data_rd, ram_data_rd_2, 32'h0});
          else
            check("data_return", {data_data_rd, inst_data_rd, inst_data_rd_2}, {ram_data_rd, 64'h0});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_port", {ram_read, ram_write, ram_address, ram_mask, ram_data_wr}, 0);
    check("rst_flags", {err_timeout, inst_stall, data_stall}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_port", {ram_read, ram_write, ram_address, ram_mask, ram_data_wr}, 0);
    step();
    // single data read with two stalled cycles
    data_read = 1; data_address = 'h10; ram_stall = 1;
    exp_q.push_back(mk(1, 0, 'h10, 4'h0, 32'h0, 0));
    @(negedge clk); check("t1_c0", {data_stall, ram_read}, 2'b10); step();
    @(negedge clk); check("t1_c1", {data_stall, ram_read}, 2'b11); step();
    @(negedge clk); check("t1_c2", {data_stall, ram_read}, 2'b11); step();
    ram_stall = 0;
    @(negedge clk); check("t1_c3", {data_stall, ram_read}, 2'b01); step();
    data_read = 0;
    @(negedge clk); check("t1_idle", {data_stall, ram_read, ram_address}, 0); step();
    // simultaneous requests: data wins, instruction follows without a bubble
    inst_read = 1; inst_address = 'h100;
    data_write = 1; data_address = 'h200; data_mask = 4'b0011; data_wr = 32'hDEAD_BEEF;
    exp_q.push_back(mk(0, 1, 'h200, 4'b0011, 32'hDEAD_BEEF, 0));
    exp_q.push_back(mk(1, 0, 'h100, 4'b1111, 32'h0, 1));
    @(negedge clk); check("t2_c0", {inst_stall, data_stall, ram_write}, 3'b110); step();
    @(negedge clk); check("t2_c1", {inst_stall, data_stall, ram_write}, 3'b101); step();
    data_write = 0;
    @(negedge clk); check("t2_c2", {inst_stall, ram_read}, 2'b01); step();
    inst_read = 0;
    @(negedge clk); check("t2_c3", {inst_stall, ram_read, ram_write}, 0); step();
    // both held: DATA, INST, DATA, INST back to back
    data_read = 1; data_address = 'h300; data_mask = 4'hC; data_wr = 32'h0;
    inst_read = 1; inst_address = 'h400;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(1, 0, 'h300, 4'hC, 32'h0, 0));
      exp_q.push_back(mk(1, 0, 'h400, 4'hF, 32'h0, 1));
    end
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) data_read = 0;
      @(negedge clk); check("t3_no_bubble", ram_read, 1); step();
    end
    inst_read = 0;
    @(negedge clk); check("t3_idle", ram_read, 0); step();
    // requester changes address mid-op; latched address must hold
    data_read = 1; data_address = 'h5; data_mask = 4'h0; ram_stall = 1;
    exp_q.push_back(mk(1, 0, 'h5, 4'h0, 32'h0, 0));
    step();
    @(negedge clk); check("t4_addr_c1", ram_address, 'h5); step();
    data_address = 'h9;
    @(negedge clk); check("t4_addr_c2", ram_address, 'h5); step();
    ram_stall = 0;
    @(negedge clk); check("t4_addr_c3", ram_address, 'h5); step();
    data_read = 0;
    @(negedge clk); step();
    // timeout after four stalled cycles, sticky past completion
    data_read = 1; data_address = 'h20; ram_stall = 1;
    exp_q.push_back(mk(1, 0, 'h20, 4'h0, 32'h0, 0));
    step();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); check("t5_no_err_yet", err_timeout, 0); step();
    end
    @(negedge clk); check("t5_err_set", err_timeout, 1); step();
    ram_stall = 0;
    @(negedge clk); check("t5_err_at_done", err_timeout, 1); step();
    data_read = 0;
    @(negedge clk); check("t5_err_sticky", {err_timeout, ram_read}, 2'b10); step();
    // reset during DATA drops the op; same request is re-granted afterwards
    data_read = 1; data_address = 'h30; ram_stall = 1;
    exp_q.push_back(mk(1, 0, 'h30, 4'h0, 32'h0, 0));
    step();
    @(negedge clk); check("t6_c1", ram_read, 1); step();
    rst = 1;
    @(negedge clk); check("t6_c2", ram_read, 1); step();
    rst = 0;
    @(negedge clk); check("t6_after_rst", {ram_read, ram_write, err_timeout, data_stall}, 4'b0001); step();
    ram_stall = 0;
    @(negedge clk); check("t6_regrant", {ram_read, data_stall}, 2'b10); step();
    data_read = 0;
    @(negedge clk); check("t6_idle", ram_read, 0); step();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
